cnn_mac_r16: RTL and testbench
==============================

Name: cnn_mac_r16

Overview:
Parametrised successor to the int8 CNN multiplier: a signed DATA_W x DATA_W radix-16 Booth multiplier with a stationary weight register, a valid pipeline, and an optional accumulate mode.
- Activations stream on a with en_a; weights are loaded on b with en_b.
- Each result is either the bare product or a running (optionally saturating) dot-product sum.
- Sits between the activation/weight buffers and the PE output collector.

Parameters:
DATA_W, 8, signed operand width; must be a multiple of 4, >=8.
ACC_W, 24, accumulator/output width; must be >=2*DATA_W.
SAT, 1, 1 = saturate accumulation at ACC_W signed limits; 0 = two's-complement wrap.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
en_a  in  1  activation valid; a is issued this cycle.
en_b  in  1  weight load; b is captured into the weight register.
a  in  DATA_W  signed activation.
b  in  DATA_W  signed weight.
mode  in  1  0 = product only; 1 = accumulate. Sampled with en_a.
clr  in  1  with en_a & mode: start a new sum (acc = product). Sampled with en_a.
p  out  ACC_W  signed result.
p_valid  out  1  p updated this cycle.
ovf  out  1  sticky saturation/overflow flag.

Behaviour:
- Reset (rst=0, async): weight register W, all pipeline registers, acc, p, p_valid and ovf go to 0. Reset mid-operation flushes in-flight issues; none produce p_valid after reset release.
- Effective weight:
  - eff_w = en_b ? b : W.
  - en_b and en_a in the same cycle: the product uses the new b.
  - W <= b on every cycle with en_b=1, independent of en_a.
- Stage 1 (edge after issue): register a, eff_w, the hard multiples 3*eff_w, 5*eff_w, 7*eff_w, and mode/clr/en_a.
- Stage 2 (following edge):
  - Radix-16 Booth-recode a into DATA_W/4 digits in [-8,8].
  - Select multiples 0..8*eff_w, shift, sum, and register the result.
  - The product is exact: 2*DATA_W bits, sign-extended to ACC_W.
- Latency: an issue at cycle t gives p_valid=1 and p valid at cycle t+2, in both modes. Throughput is 1 issue/cycle with no stalls.
- mode=0: p = product. acc is unchanged; ovf is unchanged.
- mode=1:
  - clr=1: acc = product.
  - clr=0: acc = acc + product.
  - p = new acc.
- Saturation / overflow:
  - SAT=1: on signed overflow, clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and set ovf.
  - SAT=0: wrap, and set ovf on signed overflow.
  - ovf clears only on an accumulate issue with clr=1, or on reset. On that clr issue, ovf is cleared then re-evaluated; a bare product cannot overflow.
- Bubbles: en_a=0 gives p_valid=0 two cycles later, and p holds its last value.
- Reset state: an accumulate issue with clr=0 directly after reset sums onto acc=0.
- Boundary cases:
  - most-negative x most-negative is exact (no overflow in the product).
  - A Booth top digit of +8 must be handled.

Test Plan:
- DATA_W=8, mode=0, exhaustive a,b in [-128,127], weight loaded with en_b once per 128 a values -> p == a*b at t+2 for every issue; -128*-128=16384; -128*127=-16256.
- W=3, then en_b=1 with b=-5 and en_a=1 with a=7 in the same cycle -> p=-35. Next issue a=2 without en_b -> p=-10 (W=-5 retained).
- mode=1, W=127, four issues a=127 (first with clr) -> p sequence 16129, 32258, 48387, 64516; ovf=0.
- ACC_W=16, SAT=1: same sequence -> 16129, 32258, 32767, 32767 with ovf=1 from the third result. Next clr issue a=1 -> p=127, ovf=0. With SAT=0 the third result is -17149 and ovf=1.
- Issue pattern en_a=1,0,1 with a=2,x,4 and W=10 -> p_valid pattern 1,0,1 at t+2..t+4; p=20, holds at 20, then 40.
- Assert rst=0 one cycle after an issue -> p=0, p_valid=0, ovf=0, W=0 immediately. No p_valid after release until a new issue.

Source files
------------

// File: rtl/cnn_mac_r16_if.sv
// Operand/result bundle of the radix-16 Booth MAC.
// The master drives activations and weights; the slave returns results.
interface cnn_mac_r16_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic                     en_a;
  logic                     en_b;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     mode;
  logic                     clr;
  logic signed [ACC_W-1:0]  p;
  logic                     p_valid;
  logic                     ovf;

  modport master (
    output en_a, en_b, a, b, mode, clr,
    input  p, p_valid, ovf
  );

  modport slave (
    input  en_a, en_b, a, b, mode, clr,
    output p, p_valid, ovf
  );
endinterface

// File: rtl/cnn_mac_r16.sv
// Signed DATA_W x DATA_W radix-16 Booth multiplier with a stationary weight,
// two-stage valid pipeline and optional saturating/wrapping accumulation.
module cnn_mac_r16 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  cnn_mac_r16_if.slave  bus
);

  localparam int ND = DATA_W / 4;
  localparam int MW = DATA_W + 4;
  localparam int PW = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0] r_w;
  logic signed [DATA_W-1:0] w_eff_w;
  logic signed [MW-1:0]     w_m1;
  logic signed [MW-1:0]     w_m3;
  logic signed [MW-1:0]     w_m5;
  logic signed [MW-1:0]     w_m7;

  logic signed [DATA_W-1:0] r_s1_a;
  logic signed [MW-1:0]     r_s1_m1;
  logic signed [MW-1:0]     r_s1_m3;
  logic signed [MW-1:0]     r_s1_m5;
  logic signed [MW-1:0]     r_s1_m7;
  logic                     r_s1_vld;
  logic                     r_s1_mode;
  logic                     r_s1_clr;

  logic [DATA_W:0]          w_a_win;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_of;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic                     w_ovf_next;

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_p;
  logic                     r_p_valid;
  logic                     r_ovf;

  // A weight loaded in the issue cycle is used by that same issue.
  assign w_eff_w = bus.en_b ? bus.b : r_w;
  assign w_m1    = {{4{w_eff_w[DATA_W-1]}}, w_eff_w};
  assign w_m3    = (w_m1 <<< 1) + w_m1;
  assign w_m5    = (w_m1 <<< 2) + w_m1;
  assign w_m7    = (w_m1 <<< 3) - w_m1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w <= '0;
    end else if (bus.en_b) begin
      r_w <= bus.b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_a    <= '0;
      r_s1_m1   <= '0;
      r_s1_m3   <= '0;
      r_s1_m5   <= '0;
      r_s1_m7   <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_mode <= 1'b0;
      r_s1_clr  <= 1'b0;
    end else begin
      r_s1_a    <= bus.a;
      r_s1_m1   <= w_m1;
      r_s1_m3   <= w_m3;
      r_s1_m5   <= w_m5;
      r_s1_m7   <= w_m7;
      r_s1_vld  <= bus.en_a;
      r_s1_mode <= bus.mode;
      r_s1_clr  <= bus.clr;
    end
  end

  // Digit = -8*win[4] + 4*win[3] + 2*win[2] + win[1] + win[0], range [-8,8].
  function automatic logic signed [MW-1:0] booth_pp(
    input logic [4:0]           win,
    input logic signed [MW-1:0] m1,
    input logic signed [MW-1:0] m3,
    input logic signed [MW-1:0] m5,
    input logic signed [MW-1:0] m7
  );
    logic [3:0]           t;
    logic [3:0]           mag;
    logic signed [MW-1:0] sel;
    t   = {1'b0, win[3:1]} + {3'b000, win[0]};
    mag = win[4] ? (4'd8 - t) : t;
    case (mag)
      4'd1:    sel = m1;
      4'd2:    sel = m1 <<< 1;
      4'd3:    sel = m3;
      4'd4:    sel = m1 <<< 2;
      4'd5:    sel = m5;
      4'd6:    sel = m3 <<< 1;
      4'd7:    sel = m7;
      4'd8:    sel = m1 <<< 3;
      default: sel = '0;
    endcase
    return win[4] ? -sel : sel;
  endfunction

  assign w_a_win = {r_s1_a, 1'b0};

  // Partial products are summed modulo 2^PW; the exact product always fits.
  always_comb begin
    w_prod = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      logic signed [MW-1:0] v_pp;
      v_pp   = booth_pp(w_a_win[4*i +: 5], r_s1_m1, r_s1_m3, r_s1_m5, r_s1_m7);
      w_prod = w_prod + (PW'(v_pp) << (4*i));
    end
  end

  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);

  always_comb begin
    w_of = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    if (r_s1_clr) begin
      w_acc_next = w_prod_ext;
    end else if (w_of && (SAT != 0)) begin
      w_acc_next = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_acc_next = w_sum[ACC_W-1:0];
    end
    w_ovf_next = r_s1_clr ? 1'b0 : (r_ovf | w_of);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_p       <= '0;
      r_p_valid <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_p_valid <= r_s1_vld;
      if (r_s1_vld) begin
        if (r_s1_mode) begin
          r_acc <= w_acc_next;
          r_p   <= w_acc_next;
          r_ovf <= w_ovf_next;
        end else begin
          r_p   <= w_prod_ext;
        end
      end
    end
  end

  assign bus.p       = r_p;
  assign bus.p_valid = r_p_valid;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_cnn_mac_r16.sv
// Scoreboard bench: three MAC configurations (24-bit sat, 16-bit sat,
// 16-bit wrap) share one stimulus stream; a monitor checks every cycle.
module tb_cnn_mac_r16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              en_a = 1'b0;
  logic              en_b = 1'b0;
  logic              mode = 1'b0;
  logic              clr  = 1'b0;
  logic signed [7:0] a    = '0;
  logic signed [7:0] b    = '0;

  cnn_mac_r16_if #(.DATA_W(8), .ACC_W(24)) if0 ();
  cnn_mac_r16_if #(.DATA_W(8), .ACC_W(16)) if1 ();
  cnn_mac_r16_if #(.DATA_W(8), .ACC_W(16)) if2 ();

  assign if0.en_a = en_a;
  assign if0.en_b = en_b;
  assign if0.a    = a;
  assign if0.b    = b;
  assign if0.mode = mode;
  assign if0.clr  = clr;
  assign if1.en_a = en_a;
  assign if1.en_b = en_b;
  assign if1.a    = a;
  assign if1.b    = b;
  assign if1.mode = mode;
  assign if1.clr  = clr;
  assign if2.en_a = en_a;
  assign if2.en_b = en_b;
  assign if2.a    = a;
  assign if2.b    = b;
  assign if2.mode = mode;
  assign if2.clr  = clr;

  cnn_mac_r16 #(.DATA_W(8), .ACC_W(24), .SAT(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  cnn_mac_r16 #(.DATA_W(8), .ACC_W(16), .SAT(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  cnn_mac_r16 #(.DATA_W(8), .ACC_W(16), .SAT(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct {
    logic signed [31:0] p;
    logic               ovf;
    int unsigned        cyc;
  } exp_t;

  exp_t               q [3][$];
  logic signed [31:0] last_p [3];
  int                 total = 0;
  int                 bad   = 0;
  int unsigned        cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int idx, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, idx, act, req, $time);
    end
  endtask

  task automatic mon(input int idx, input logic v, input logic signed [31:0] pv, input logic ov);
    exp_t e;
    if (v) begin
      if (q[idx].size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid dut%0d: got p_valid=1 expected 0 (t=%0t)", idx, $time);
      end else begin
        e = q[idx].pop_front();
        chk("p", idx, pv, e.p);
        chk("ovf", idx, ov, e.ovf);
        chk("latency_cycle", idx, cyc, e.cyc);
        last_p[idx] = e.p;
      end
    end else begin
      chk("hold_p", idx, pv, last_p[idx]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, if0.p_valid, if0.p, if0.ovf);
      mon(1, if1.p_valid, if1.p, if1.ovf);
      mon(2, if2.p_valid, if2.p, if2.ovf);
    end
  end

  task automatic issue(input logic eb, input int bv, input int av, input logic md, input logic cl,
                       input int e0, input int e1, input int e2,
                       input logic o0, input logic o1, input logic o2);
    exp_t e;
    en_a = 1'b1;
    en_b = eb;
    b    = 8'(bv);
    a    = 8'(av);
    mode = md;
    clr  = cl;
    e.cyc = cyc + 2;
    e.p = e0; e.ovf = o0; q[0].push_back(e);
    e.p = e1; e.ovf = o1; q[1].push_back(e);
    e.p = e2; e.ovf = o2; q[2].push_back(e);
    @(posedge clk); #1;
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic loadw(input int bv);
    en_b = 1'b1;
    b    = 8'(bv);
    @(posedge clk); #1;
    en_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_rst();
    chk("rst_p", 0, if0.p, 0);
    chk("rst_p", 1, if1.p, 0);
    chk("rst_p", 2, if2.p, 0);
    chk("rst_p_valid", 0, if0.p_valid, 0);
    chk("rst_p_valid", 1, if1.p_valid, 0);
    chk("rst_p_valid", 2, if2.p_valid, 0);
    chk("rst_ovf", 0, if0.ovf, 0);
    chk("rst_ovf", 1, if1.ovf, 0);
    chk("rst_ovf", 2, if2.ovf, 0);
  endtask

  initial begin
    last_p = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk_rst();
    rst = 1'b1;
    idle(2);

    // exhaustive products, weight reloaded every 128 activations
    for (int bi = -128; bi <= 127; bi++) begin
      for (int ai = -128; ai <= 127; ai++) begin
        issue((ai == -128) || (ai == 0), bi, ai, 1'b0, 1'b0,
              ai * bi, ai * bi, ai * bi, 1'b0, 1'b0, 1'b0);
      end
    end
    idle(3);

    // same-cycle weight load and issue
    loadw(3);
    issue(1'b1, -5, 7, 1'b0, 1'b0, -35, -35, -35, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 0, 2, 1'b0, 1'b0, -10, -10, -10, 1'b0, 1'b0, 1'b0);

    // positive accumulation: 24-bit exact, 16-bit saturate, 16-bit wrap
    loadw(127);
    issue(1'b0, 0, 127, 1'b1, 1'b1, 16129, 16129, 16129, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 0, 127, 1'b1, 1'b0, 32258, 32258, 32258, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 0, 127, 1'b1, 1'b0, 48387, 32767, -17149, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 0, 127, 1'b1, 1'b0, 64516, 32767, -1020, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 0, 1, 1'b1, 1'b1, 127, 127, 127, 1'b0, 1'b0, 1'b0);

    // negative accumulation, then a bare product leaves ovf sticky
    loadw(-128);
    issue(1'b0, 0, 127, 1'b1, 1'b1, -16256, -16256, -16256, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 0, 127, 1'b1, 1'b0, -32512, -32512, -32512, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 0, 127, 1'b1, 1'b0, -48768, -32768, 16768, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 0, 2, 1'b0, 1'b0, -256, -256, -256, 1'b0, 1'b1, 1'b1);

    // bubble in the issue stream
    loadw(10);
    issue(1'b0, 0, 2, 1'b0, 1'b0, 20, 20, 20, 1'b0, 1'b1, 1'b1);
    idle(1);
    issue(1'b0, 0, 4, 1'b0, 1'b0, 40, 40, 40, 1'b0, 1'b1, 1'b1);
    idle(3);

    // reset one cycle after an issue flushes it
    en_a = 1'b1;
    a    = 8'sd3;
    mode = 1'b0;
    clr  = 1'b0;
    @(posedge clk); #1;
    en_a = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      last_p[i] = 0;
    end
    #1;
    chk_rst();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(4);

    // weight cleared by reset; accumulate without clr starts from acc=0
    issue(1'b0, 0, 5, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3, 5, 1'b1, 1'b0, 15, 15, 15, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 0, -4, 1'b1, 1'b0, 3, 3, 3, 1'b0, 1'b0, 1'b0);
    idle(4);

    for (int i = 0; i < 3; i++) chk("drain", i, q[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
